// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port
// between N requesters. The owner of a grant may write up to MAX_BURST words
// before priority rotates to the next index. The FIFO full flag stalls the
// burst in place.
// Optional build macro FIFO_WR_ARB_STATS_EN adds a saturating stall counter.
// Without the macro, stall_cnt is tied to zero.
module fifo_wr_arbiter #(
  parameter int DW        = 32,
  parameter int N         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    gnt,
  output logic [DW-1:0]   fifo_din,
  output logic            fifo_wen,
  input  logic            fifo_full,
  output logic            busy,
  output logic [15:0]     stall_cnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;

  logic [DW-1:0] slice_w [N];
  logic [IW-1:0] found_idx;
  logic [IW-1:0] next_idx;
  logic [IW:0]   cand_sum;
  logic          found;
  logic          sel_req;

  // Split the flat request data bus into one word per requester.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign slice_w[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  assign sel_req  = req[gnt_idx_q];
  assign next_idx = (gnt_idx_q == IW'(N - 1)) ? '0 : gnt_idx_q + 1'b1;

  // Find the first requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    found_idx = rr_ptr_q;
    found     = 1'b0;
    cand_sum  = '0;
    for (int k = 0; k < N; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand_sum >= (IW+1)'(N)) begin
        cand_sum = cand_sum - (IW+1)'(N);
      end
      if (!found && req[cand_sum[IW-1:0]]) begin
        found_idx = cand_sum[IW-1:0];
        found     = 1'b1;
      end
    end
  end

  // Next-state and output logic; write strobes depend combinationally on req and full.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_idx_d  = gnt_idx_q;
    beat_cnt_d = beat_cnt_q;
    gnt        = '0;
    ack        = '0;
    fifo_wen   = 1'b0;
    fifo_din   = '0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_idx_d  = found_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        busy           = 1'b1;
        gnt[gnt_idx_q] = 1'b1;
        fifo_din       = slice_w[gnt_idx_q];
        if (!sel_req) begin
          // Owner released the grant: rotate without writing.
          state_d  = IDLE;
          rr_ptr_d = next_idx;
        end else if (!fifo_full) begin
          fifo_wen       = 1'b1;
          ack[gnt_idx_q] = 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d  = IDLE;
            rr_ptr_d = next_idx;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
        // Otherwise full stalls the burst: state, count and grant are held.
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_idx_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  assign stall_cnt_d = (state_q == BURST && sel_req && fifo_full && stall_cnt_q != 16'hFFFF)
                       ? stall_cnt_q + 16'd1 : stall_cnt_q;

  // Count cycles lost to FIFO full while a burst owner is waiting; saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (N=4, MAX_BURST=4, DW=32).
// Inputs change just after the falling edge, and outputs are checked 1ns later.
module tb_fifo_wr_arbiter;

  localparam int DW = 32;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   fifo_din;
  logic            fifo_wen;
  logic            fifo_full;
  logic            busy;
  logic [15:0]     stall_cnt;

  int num_checks = 0;
  int num_errors = 0;

  fifo_wr_arbiter #(.DW(DW), .N(N), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .gnt       (gnt),
    .fifo_din  (fifo_din),
    .fifo_wen  (fifo_wen),
    .fifo_full (fifo_full),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int idx, input logic [31:0] val);
    req_data[idx*DW +: DW] = val;
  endtask

  // Check one cycle of outputs, then advance to the next falling edge.
  task automatic beat(input string tag, input logic [3:0] eg, input logic ew,
                      input logic [31:0] ed, input logic eb);
    #1;
    check_val({tag, ".gnt"},  {28'd0, gnt}, {28'd0, eg});
    check_val({tag, ".wen"},  {31'd0, fifo_wen}, {31'd0, ew});
    check_val({tag, ".ack"},  {28'd0, ack}, ew ? {28'd0, eg} : 32'd0);
    check_val({tag, ".din"},  fifo_din, ed);
    check_val({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    $display("%0t %s req=%b gnt=%b ack=%b wen=%b din=%h busy=%b",
             $time, tag, req, gnt, ack, fifo_wen, fifo_din, busy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    fifo_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    req_data = '0;
    do_reset();

    // Reset state
    #1;
    check_val("rst.gnt",   {28'd0, gnt}, 32'd0);
    check_val("rst.ack",   {28'd0, ack}, 32'd0);
    check_val("rst.wen",   {31'd0, fifo_wen}, 32'd0);
    check_val("rst.din",   fifo_din, 32'd0);
    check_val("rst.busy",  {31'd0, busy}, 32'd0);
    check_val("rst.stall", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk);

    // Single requester: IDLE, A0..A3, IDLE, A4, A5, release
    req = 4'b0001;
    set_data(0, 32'hA0);
    beat("single.idle", 4'b0000, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      set_data(0, 32'hA0 + k);
      beat("single.wr", 4'b0001, 1'b1, 32'hA0 + k, 1'b1);
    end
    set_data(0, 32'hA4);
    beat("single.idle2", 4'b0000, 1'b0, 32'h0, 1'b0);
    beat("single.wr4", 4'b0001, 1'b1, 32'hA4, 1'b1);
    set_data(0, 32'hA5);
    beat("single.wr5", 4'b0001, 1'b1, 32'hA5, 1'b1);
    req = 4'b0000;
    beat("single.rel", 4'b0001, 1'b0, 32'hA5, 1'b1);
    beat("single.idle3", 4'b0000, 1'b0, 32'h0, 1'b0);

    // All requesting: grant order 0,1,2,3,0 with 4 beats each
    do_reset();
    for (int i = 0; i < N; i++) set_data(i, 32'hC0 + i);
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      int g;
      g = r % N;
      beat("all.idle", 4'b0000, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 4; k++) begin
        beat("all.wr", 4'(1 << g), 1'b1, 32'hC0 + g, 1'b1);
      end
    end
    req = 4'b0000;
    beat("all.end", 4'b0000, 1'b0, 32'h0, 1'b0);

    // Full backpressure on requester 1 after two beats
    do_reset();
    req = 4'b0010;
    set_data(1, 32'hD0);
    beat("full.idle", 4'b0000, 1'b0, 32'h0, 1'b0);
    beat("full.wr0", 4'b0010, 1'b1, 32'hD0, 1'b1);
    set_data(1, 32'hD1);
    beat("full.wr1", 4'b0010, 1'b1, 32'hD1, 1'b1);
    set_data(1, 32'hD2);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      beat("full.stall", 4'b0010, 1'b0, 32'hD2, 1'b1);
    end
    fifo_full = 1'b0;
    beat("full.wr2", 4'b0010, 1'b1, 32'hD2, 1'b1);
    set_data(1, 32'hD3);
    beat("full.wr3", 4'b0010, 1'b1, 32'hD3, 1'b1);
    set_data(1, 32'hD4);
    beat("full.idle2", 4'b0000, 1'b0, 32'h0, 1'b0);
    req = 4'b0000;
`ifdef FIFO_WR_ARB_STATS_EN
    check_val("full.stall_cnt", {16'd0, stall_cnt}, 32'd5);
`else
    check_val("full.stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    @(negedge clk);

    // Early release: requester 2 drops after two acks; rr_ptr=3 picks 3 over 0
    do_reset();
    set_data(0, 32'h90);
    set_data(2, 32'hE0);
    set_data(3, 32'hF0);
    req = 4'b0100;
    beat("early.idle", 4'b0000, 1'b0, 32'h0, 1'b0);
    req = 4'b1101;
    beat("early.wr0", 4'b0100, 1'b1, 32'hE0, 1'b1);
    set_data(2, 32'hE1);
    beat("early.wr1", 4'b0100, 1'b1, 32'hE1, 1'b1);
    req = 4'b1001;
    beat("early.rel", 4'b0100, 1'b0, 32'hE1, 1'b1);
    beat("early.idle2", 4'b0000, 1'b0, 32'h0, 1'b0);
    beat("early.gnt3", 4'b1000, 1'b1, 32'hF0, 1'b1);
    req = 4'b0000;
    beat("early.rel3", 4'b1000, 1'b0, 32'hF0, 1'b1);
    beat("early.idle3", 4'b0000, 1'b0, 32'h0, 1'b0);

    // Reset in the middle of a beat: outputs drop before the next edge
    do_reset();
    req = 4'b0010;
    set_data(1, 32'h11);
    beat("rstmid.idle", 4'b0000, 1'b0, 32'h0, 1'b0);
    #1;
    check_val("rstmid.pre_wen", {31'd0, fifo_wen}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("rstmid.wen",  {31'd0, fifo_wen}, 32'd0);
    check_val("rstmid.gnt",  {28'd0, gnt}, 32'd0);
    check_val("rstmid.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1000;
    set_data(3, 32'h33);
    beat("rstmid.idle2", 4'b0000, 1'b0, 32'h0, 1'b0);
    beat("rstmid.gnt3", 4'b1000, 1'b1, 32'h33, 1'b1);
    req = 4'b0000;
    beat("rstmid.rel", 4'b1000, 1'b0, 32'h33, 1'b1);

`ifdef FIFO_WR_ARB_STATS_EN
    // Long stall saturates the counter
    do_reset();
    req = 4'b0001;
    set_data(0, 32'h55);
    beat("sat.idle", 4'b0000, 1'b0, 32'h0, 1'b0);
    fifo_full = 1'b1;
    repeat (70000) @(negedge clk);
    #1;
    check_val("sat.stall_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
    do_reset();
`else
    #1;
    check_val("nostats.stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
